// File: rtl/hazard3_pmp_fault_capture.sv
// -----------------------------------------------------------------------------
// hazard3_pmp_fault_capture
//
// Sits after the PMP checkers. It takes the per-cycle fetch and load/store
// kill verdicts and turns them into one pending exception request toward the
// trap logic. The request carries a RISC-V cause and tval, and it is held
// until exc_ack. When faults overlap, program order decides: a load/store
// fault is older than a fetch fault. The block also keeps a saturating fault
// counter and a sticky overrun flag for debug.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_check_valid       i_addr/i_kill describe a real fetch this cycle
//   i_addr, i_kill      fetch address and its PMP access-fault verdict
//   d_check_valid       d_addr/d_kill/d_write describe a real load/store
//   d_addr, d_kill      load/store address and its PMP access-fault verdict
//   d_write             1 = store/AMO, 0 = load
//   flush               fetch redirect; squashes younger (fetch) faults
//   exc_req             a fault is pending toward trap logic
//   exc_cause           1 = instr access, 5 = load access, 7 = store/AMO
//   exc_tval            faulting address
//   exc_ack             trap logic consumed the request (qualified by exc_req)
//   overrun             sticky: a load/store fault was dropped
//   fault_count         saturating count of qualified faults
//   count_clr           clears fault_count and overrun
// -----------------------------------------------------------------------------
module hazard3_pmp_fault_capture #(
    parameter int W_ADDR = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_check_valid,
    input  logic [W_ADDR-1:0] i_addr,
    input  logic              i_kill,
    input  logic              d_check_valid,
    input  logic [W_ADDR-1:0] d_addr,
    input  logic              d_write,
    input  logic              d_kill,
    input  logic              flush,
    output logic              exc_req,
    output logic [3:0]        exc_cause,
    output logic [W_ADDR-1:0] exc_tval,
    input  logic              exc_ack,
    output logic              overrun,
    output logic [CNT_W-1:0]  fault_count,
    input  logic              count_clr
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PEND_I = 2'd1;
    localparam logic [1:0] PEND_D = 2'd2;

    localparam logic [3:0] CAUSE_INSTR = 4'd1;
    localparam logic [3:0] CAUSE_LOAD  = 4'd5;
    localparam logic [3:0] CAUSE_STORE = 4'd7;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [3:0]        cause_nxt;
    logic [W_ADDR-1:0] tval_nxt;
    logic              ovr_set;

    // A fetch fault that comes with a redirect belongs to the squashed path.
    logic qi;
    logic qd;
    logic free;
    logic [3:0] d_cause;

    assign qi      = i_check_valid & i_kill & ~flush;
    assign qd      = d_check_valid & d_kill;
    assign exc_req = (state != IDLE);
    // An ack while nothing is pending does nothing.
    assign free    = (state == IDLE) | (exc_req & exc_ack);
    assign d_cause = d_write ? CAUSE_STORE : CAUSE_LOAD;

    // NOTE: every output of this block gets a default first so that no path
    //       leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        cause_nxt = exc_cause;
        tval_nxt  = exc_tval;
        ovr_set   = 1'b0;
        if (free) begin
            // With an ack in the same cycle, a new fault goes straight in and
            // exc_req does not drop.
            if (qd) begin
                state_nxt = PEND_D;
                cause_nxt = d_cause;
                tval_nxt  = d_addr;
            end else if (qi) begin
                state_nxt = PEND_I;
                cause_nxt = CAUSE_INSTR;
                tval_nxt  = i_addr;
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                PEND_I: begin
                    // The pending fetch is younger than any load/store seen
                    // now. The fetch will be refetched, so replacing it is
                    // not an overrun.
                    if (qd) begin
                        state_nxt = PEND_D;
                        cause_nxt = d_cause;
                        tval_nxt  = d_addr;
                    end else if (flush) begin
                        state_nxt = IDLE;
                    end
                end
                PEND_D: begin
                    // The held load/store fault is the oldest. A newer data
                    // fault is lost, so record that.
                    ovr_set = qd;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Add up to two faults per cycle and clamp at the maximum. The extra bit
    // catches the +2 step from max-1.
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_sum = {1'b0, fault_count} + {{CNT_W{1'b0}}, qi} + {{CNT_W{1'b0}}, qd};
    assign cnt_nxt = (cnt_sum > {1'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    //       therefore samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            exc_cause   <= 4'd0;
            exc_tval    <= '0;
            overrun     <= 1'b0;
            fault_count <= '0;
        end else begin
            state     <= state_nxt;
            exc_cause <= cause_nxt;
            exc_tval  <= tval_nxt;
            // The clear wins over this cycle's events, which are lost.
            if (count_clr) begin
                overrun     <= 1'b0;
                fault_count <= '0;
            end else begin
                if (ovr_set) overrun <= 1'b1;
                fault_count <= cnt_nxt;
            end
        end
    end

endmodule

// File: doc/hazard3_pmp_fault_capture.md
Name: hazard3_pmp_fault_capture

Overview:
- Downstream stage of the PMP unit. Consumes the per-cycle fetch and load/store kill verdicts, together with the queried addresses.
- Registers each qualified fault into a single-entry pending slot and presents it to trap logic as an exception request with RISC-V cause and tval. The request is held until acknowledged.
- Arbitrates simultaneous and overlapping faults by program order: a load/store fault is older than a fetch fault.
- Keeps a saturating fault counter and a sticky overrun flag for debug.

Parameters:
W_ADDR, 32, address width (fetch/data address and tval width)
CNT_W, 8, width of saturating fault counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_check_valid  input  1  i_addr/i_kill describe a real fetch this cycle
i_addr  input  W_ADDR  fetch address queried against PMP
i_kill  input  1  PMP fetch verdict: access fault
d_check_valid  input  1  d_addr/d_kill describe a real load/store this cycle
d_addr  input  W_ADDR  load/store address queried against PMP
d_write  input  1  1 = store/AMO, 0 = load
d_kill  input  1  PMP load/store verdict: access fault
flush  input  1  fetch redirect; squashes younger (fetch) faults
exc_req  output  1  fault pending toward trap logic
exc_cause  output  4  1 = instr access, 5 = load access, 7 = store/AMO access
exc_tval  output  W_ADDR  faulting address
exc_ack  input  1  trap logic consumed the request (qualified by exc_req)
overrun  output  1  sticky: a load/store fault was dropped
fault_count  output  CNT_W  saturating count of qualified faults
count_clr  input  1  clears fault_count and overrun

Behaviour:
- Interface: clock clk; reset rst_n, asynchronous, active-low.
- Reset values: state IDLE; exc_req=0; exc_cause=0; exc_tval=0; overrun=0; fault_count=0.
- Qualified faults:
  - qi = i_check_valid & i_kill & !flush
  - qd = d_check_valid & d_kill
- State machine: IDLE, PEND_I, PEND_D.
  - exc_req = (state != IDLE), registered.
  - Latency: a fault in cycle N gives exc_req=1 in cycle N+1.
- Slot free this cycle: free = (state==IDLE) | (exc_req & exc_ack). An ack in IDLE is ignored.
- Capture when free:
  - If qd: go to PEND_D, cause = d_write ? 7 : 5, tval = d_addr.
  - Else if qi: go to PEND_I, cause = 1, tval = i_addr.
  - Else: go to IDLE.
  - Ack and new fault in the same cycle: the new fault is captured and exc_req stays 1 with no bubble.
- PEND_I without ack:
  - qd replaces the entry: go to PEND_D, load cause/tval from the data side. Overrun is not set, since the fetch is younger and will be refetched.
  - Else if flush: go to IDLE. The pending fetch fault is squashed.
  - New qi is dropped silently.
- PEND_D without ack:
  - Any new qd is dropped and sets overrun.
  - qi is dropped silently.
  - flush has no effect on PEND_D.
- flush and ack in the same cycle in PEND_I: the slot is free; capture rules apply, with qi already masked by flush.
- exc_cause and exc_tval are stable while exc_req=1 and no replacement occurs. They keep their last value after returning to IDLE.
- fault_count:
  - Each cycle, adds qi+qd (0..2), whether the fault is captured, replaced or dropped.
  - Saturates at 2^CNT_W-1 with no wrap, including a +2 step from max-1.
- count_clr:
  - Sets fault_count=0 and overrun=0.
  - Takes priority over that cycle's increment and overrun set; those events are lost.
- Reset asserted mid-request: immediately returns to reset values; the pending fault is discarded.

Test Plan:
- Load fault capture: d_check_valid=1, d_kill=1, d_write=0, d_addr=0x2000_0004 in cycle N -> cycle N+1: exc_req=1, cause=5, tval=0x2000_0004; held until exc_ack; fault_count=1.
- Simultaneous faults: qi(i_addr=0x100) and store qd(d_addr=0x400) in the same cycle -> cause=7, tval=0x400; fault_count=2; overrun=0.
- Replacement and flush:
  - While PEND_I (tval=0x100), a load fault at 0x800 -> cause=5, tval=0x800, overrun=0.
  - Separately, PEND_I plus flush -> exc_req=0 next cycle.
- Overrun: PEND_D with no ack, second qd at 0x900 -> tval unchanged, overrun=1; count_clr -> overrun=0, fault_count=0.
- Back-to-back: exc_ack in the same cycle as a new qi at 0x200 -> exc_req stays 1, next cause=1, tval=0x200.
- Saturation: with CNT_W=2, five faults including one dual-fault cycle from count 2 -> fault_count=3, no wrap; async reset asserted mid-PEND_D -> exc_req=0 immediately.
